div_seq_ctrl: RTL and testbench
===============================

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the divide-ratio field.
REQ-002 SHALL have parameter CNT_W, default 16, width of the period counter.
REQ-003 SHALL have parameter DIV_RST, default 4, active ratio after reset.
REQ-004 SHALL have port clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin dividing.
REQ-007 SHALL have port stop  input  1  one-cycle request to end dividing, glitch-free.
REQ-008 SHALL have port cfg_valid  input  1  new ratio offered.
REQ-009 SHALL have port cfg_div  input  DIV_W  half-period length minus 1.
REQ-010 SHALL have port cfg_ready  output  1  ratio accepted when cfg_valid && cfg_ready.
REQ-011 SHALL have port clk_out  output  1  divided clock, registered.
REQ-012 SHALL have port tick  output  1  one-cycle pulse on every clk_out toggle.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port period_cnt  output  CNT_W  completed clk_out rising edges since the last start.

Function
REQ-015 SHALL implement states IDLE, RUN and STOPPING.
REQ-016 IDLE: count=0, clk_out=0; start moves to RUN next edge; stop ignored.
REQ-017 RUN: count increments each cycle; on the edge where count==div_active, count<=0, clk_out toggles, tick=1 for that cycle.
REQ-018 Half-period SHALL be div_active+1 cycles; first toggle 5 cycles after entering RUN at DIV_RST=4; full period 2*(div_active+1).
REQ-019 cfg_div==0 SHALL be accepted and clamped to 1.
REQ-020 In IDLE, cfg_ready=1 and the accepted value loads div_active next edge; start plus cfg in the same cycle SHALL use the new ratio from the first half-period.
REQ-021 In RUN/STOPPING, an accepted value SHALL go to a pending register, cfg_ready=0 while pending, applied at the next boundary (count==div_active), new ratio effective from the following half-period.
REQ-022 RUN+stop with clk_out=0: next state IDLE, count=0, no clk_out transition.
REQ-023 RUN+stop with clk_out=1: next state STOPPING; counting continues; at next boundary clk_out falls, tick=1, state IDLE.
REQ-024 start+stop in the same RUN cycle: stop wins; start in RUN or STOPPING ignored.
REQ-025 A pending ratio SHALL be applied on entry to IDLE if not yet applied.
REQ-026 clk_out SHALL never produce a high or low phase shorter than the active half-period, except a truncated low phase at stop.

Reset
REQ-027 reset low SHALL asynchronously force state=IDLE, count=0, clk_out=0, tick=0, busy=0, cfg_ready=1, pending cleared, div_active=DIV_RST, period_cnt=0.
REQ-028 Reset mid-RUN SHALL drop clk_out to 0 immediately; no tick generated.

Configuration
REQ-029 Macro DIV_SEQ_PERIOD_CNT_EN defined: period_cnt increments on each clk_out rising toggle, clears on start acceptance, wraps all-ones->0.
REQ-030 Macro undefined: period_cnt tied to 0, no counter flops.

Structure
REQ-031 Package div_seq_pkg SHALL hold the state enum, DIV_W/CNT_W/DIV_RST defaults.
REQ-032 Sub-module div_seq_core SHALL hold count, boundary compare and clk_out toggle; FSM, cfg handshake and period counter stay in div_seq_ctrl.

Verification
REQ-033 Reset, start, no cfg -> first clk_out rise 5 cycles after RUN entry, period 10, tick every 5 cycles.
REQ-034 IDLE cfg_div=2 with start -> period 6 cycles, tick every 3.
REQ-035 RUN at ratio 4, cfg_div=1 mid-half-period -> cfg_ready low until boundary, then half-period 2 cycles.
REQ-036 stop while clk_out=1 -> clk_out high until boundary, then falls with tick; busy low next cycle; stop while clk_out=0 -> IDLE next edge, no tick.
REQ-037 reset asserted mid-RUN -> all outputs at REQ-027 values same cycle; release then start -> ratio DIV_RST.
REQ-038 With DIV_SEQ_PERIOD_CNT_EN, CNT_W=4, 17 periods -> period_cnt reads 1; restart -> 0.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequenced clock divider: FSM state encoding and
// default parameter values.
package div_seq_pkg;

    localparam int DIV_W_DEF   = 8;   // divide-ratio field width
    localparam int CNT_W_DEF   = 16;  // period counter width
    localparam int DIV_RST_DEF = 4;   // ratio loaded by reset

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/div_seq_core.sv
// Divider datapath: half-period counter, boundary compare and the registered
// clk_out / tick pair. The controlling FSM decides when it runs or clears.
module div_seq_core #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             reset,     // async, active low
    input  logic             i_run,     // FSM is in RUN or STOPPING
    input  logic             i_clr,     // drop to idle without a clk_out edge
    input  logic [DIV_W-1:0] i_div,     // active half-period length minus 1
    output logic             o_bnd,     // this cycle ends a half-period
    output logic             o_clk,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_bnd = i_run && (r_cnt == i_div);

    // Count through the half-period; toggle clk_out and pulse tick at its end.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else if (!i_run || i_clr) begin
            // i_clr only fires while clk_out is already low, so forcing 0 is safe
            r_cnt  <= '0;
            o_clk  <= 1'b0;
            o_tick <= 1'b0;
        end else if (o_bnd) begin
            r_cnt  <= '0;
            o_clk  <= ~o_clk;
            o_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + DIV_W'(1);
            o_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequenced clock divider top: start/stop FSM, ratio handshake with pending
// register, and optional period counter (enabled by DIV_SEQ_PERIOD_CNT_EN).
module div_seq_ctrl
    import div_seq_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] period_cnt
);

    state_t           r_state;
    state_t           w_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_pend;
    logic             r_pend_vld;
    logic [DIV_W-1:0] w_cfg_clamp;
    logic             w_acc;
    logic             w_bnd;
    logic             w_clr;

    // A ratio of 0 would toggle every cycle; it is promoted to 1.
    assign w_cfg_clamp = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
    assign cfg_ready   = (r_state == ST_IDLE) || !r_pend_vld;
    assign w_acc       = cfg_valid && cfg_ready;
    assign busy        = (r_state != ST_IDLE);

    div_seq_core #(.DIV_W(DIV_W)) u_core (
        .clk_in (clk_in),
        .reset  (reset),
        .i_run  (busy),
        .i_clr  (w_clr),
        .i_div  (r_div),
        .o_bnd  (w_bnd),
        .o_clk  (clk_out),
        .o_tick (tick)
    );

    // Next state; stop wins over start, and a high phase is always completed.
    always_comb begin
        w_nxt = r_state;
        w_clr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    if (!clk_out) begin
                        w_nxt = ST_IDLE;
                        w_clr = 1'b1;
                    end else if (w_bnd) begin
                        w_nxt = ST_IDLE;   // the boundary edge is the falling edge
                    end else begin
                        w_nxt = ST_STOPPING;
                    end
                end
            end
            ST_STOPPING: begin
                if (w_bnd) w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    // Ratio handshake: direct load in IDLE, otherwise hold in pending until the
    // next half-period boundary or the return to IDLE, whichever comes first.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_div      <= DIV_W'(DIV_RST);
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_acc) r_div <= w_cfg_clamp;
        end else if (w_nxt == ST_IDLE) begin
            if (w_acc)           r_div <= w_cfg_clamp;
            else if (r_pend_vld) r_div <= r_pend;
            r_pend_vld <= 1'b0;
        end else if (w_bnd && r_pend_vld) begin
            r_div      <= r_pend;
            r_pend_vld <= 1'b0;
        end else if (w_acc) begin
            r_pend     <= w_cfg_clamp;
            r_pend_vld <= 1'b1;
        end
    end

`ifdef DIV_SEQ_PERIOD_CNT_EN
    logic [CNT_W-1:0] r_pcnt;

    // Count rising clk_out edges since the last accepted start; wraps naturally.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)                            r_pcnt <= '0;
        else if (r_state == ST_IDLE && start)  r_pcnt <= '0;
        else if (w_bnd && !clk_out && !w_clr)  r_pcnt <= r_pcnt + CNT_W'(1);
    end

    assign period_cnt = r_pcnt;
`else
    assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: a half-period "cycles remaining" model
// compared on every negedge, plus directed literal expectations.
module tb_div_seq_ctrl;

    localparam int DIV_W   = 8;
    localparam int CNT_W   = 4;
    localparam int DIV_RST = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_div = '0;
    logic             cfg_ready, clk_out, tick, busy;
    logic [CNT_W-1:0] period_cnt;

    always #5 clk = ~clk;

    div_seq_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
        .clk_in     (clk),
        .reset      (rst_n),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .period_cnt (period_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: mode 0 idle / 1 run / 2 stopping; m_left = cycles left in half-period.
    int m_mode, m_left, m_half, m_pend, m_clk, m_tick, m_pcnt;

    function automatic int m_ready();
        return (m_mode == 0 || m_pend < 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_half = DIV_RST + 1; m_pend = -1;
        m_clk = 0; m_tick = 0; m_pcnt = 0;
    endtask

    task automatic model_step();
        int nv;
        bit acc, bnd, go_idle;
        nv      = (cfg_div == 0) ? 1 : int'(cfg_div);
        acc     = cfg_valid && (m_ready() == 1);
        bnd     = (m_mode != 0) && (m_left == 1);
        go_idle = 1'b0;
        m_tick  = 0;
        if (m_mode == 0) begin
            if (acc) m_half = nv + 1;
            if (start) begin m_mode = 1; m_left = m_half; m_pcnt = 0; end
        end else begin
            if (m_mode == 1 && stop && m_clk == 0) begin
                go_idle = 1'b1;
            end else if (bnd) begin
                m_tick = 1;
                m_clk  = 1 - m_clk;
`ifdef DIV_SEQ_PERIOD_CNT_EN
                if (m_clk == 1) m_pcnt = (m_pcnt + 1) % (1 << CNT_W);
`endif
                if (m_mode == 2 || stop) go_idle = 1'b1;
                else begin
                    if (m_pend >= 0) begin m_half = m_pend + 1; m_pend = -1; end
                    m_left = m_half;
                end
            end else begin
                m_left--;
                if (m_mode == 1 && stop) m_mode = 2;
            end
            if (go_idle) begin
                m_mode = 0;
                if (acc) m_half = nv + 1;
                else if (m_pend >= 0) m_half = m_pend + 1;
                m_pend = -1;
            end else if (acc) begin
                m_pend = nv;
            end
        end
    endtask

    always @(posedge clk) if (rst_n) model_step();

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("clk_out",    int'(clk_out),    m_clk);
            chk("tick",       int'(tick),       m_tick);
            chk("busy",       int'(busy),       (m_mode != 0) ? 1 : 0);
            chk("cfg_ready",  int'(cfg_ready),  m_ready());
            chk("period_cnt", int'(period_cnt), m_pcnt);
        end
    end

    task automatic wait_clk(input logic lvl, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (clk_out !== lvl && n < 200);
        if (clk_out !== lvl) chk("clk_out_timeout", 0, 1);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (tick !== 1'b1 && n < 200);
        if (tick !== 1'b1) chk("tick_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clk); stop = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_clk"},   int'(clk_out),    0);
        chk({tag, "_tick"},  int'(tick),       0);
        chk({tag, "_busy"},  int'(busy),       0);
        chk({tag, "_ready"}, int'(cfg_ready),  1);
        chk({tag, "_pcnt"},  int'(period_cnt), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int exp17;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Default ratio 4: half-period 5.
        pulse_start();
        wait_clk(1'b1, n);  chk("r4_first_rise", n, 5);
        wait_tick(n);       chk("r4_tick_gap", n, 5);
        wait_tick(n);       chk("r4_tick_gap2", n, 5);

        // Stop with clk_out high: full high phase, then fall with tick.
        pulse_stop();
        chk("stop_hi_busy", int'(busy), 1);
        chk("stop_hi_clk",  int'(clk_out), 1);
        wait_clk(1'b0, n);  chk("stop_hi_hold", n, 4);
        chk("stop_hi_tick", int'(tick), 1);
        chk("stop_hi_idle", int'(busy), 0);
        @(negedge clk);

        // Ratio 2 loaded together with start.
        cfg_valid = 1'b1; cfg_div = 8'd2;
        pulse_start();
        cfg_valid = 1'b0;
        wait_clk(1'b1, n);  chk("r2_first_rise", n, 3);
        wait_tick(n);       chk("r2_tick_gap", n, 3);
        // Stop with clk_out low: IDLE next edge, no tick.
        pulse_stop();
        chk("stop_lo_busy", int'(busy), 0);
        chk("stop_lo_tick", int'(tick), 0);
        @(negedge clk);

        // Ratio 0 clamps to 1.
        cfg_valid = 1'b1; cfg_div = 8'd0;
        pulse_start();
        cfg_valid = 1'b0;
        wait_clk(1'b1, n);  chk("r0_first_rise", n, 2);
        wait_tick(n);       chk("r0_tick_gap", n, 2);
        pulse_stop();
        @(negedge clk);

        // Mid-run ratio change 4 -> 1.
        cfg_valid = 1'b1; cfg_div = 8'd4;
        @(negedge clk);
        cfg_valid = 1'b0;
        pulse_start();
        repeat (2) @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 8'd1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("pend_ready_lo", int'(cfg_ready), 0);
        wait_tick(n);       chk("pend_apply_wait", n, 2);
        chk("pend_ready_hi", int'(cfg_ready), 1);
        wait_tick(n);       chk("r1_tick_gap", n, 2);

        // Asynchronous reset in the middle of a run.
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_clk(1'b1, n);  chk("rst_ratio_rise", n, 5);

        // 17 rising edges since start.
        for (int i = 0; i < 16; i++) begin
            wait_clk(1'b0, n);
            wait_clk(1'b1, n);
        end
`ifdef DIV_SEQ_PERIOD_CNT_EN
        exp17 = 1;
`else
        exp17 = 0;
`endif
        chk("pcnt_17", int'(period_cnt), exp17);
        pulse_stop();
        wait_clk(1'b0, n);
        @(negedge clk);
        pulse_start();
        chk("pcnt_restart", int'(period_cnt), 0);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
